// File: rtl/kijelzo_vezerlo.sv
// rtl/kijelzo_vezerlo.sv - divider result display on a 4-digit multiplexed 7-segment panel
module kijelzo_vezerlo #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic       hiba,
  input  logic [3:0] hanyados,
  input  logic [3:0] maradek,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

  localparam logic [1:0] URES     = 2'd0;
  localparam logic [1:0] EREDMENY = 2'd1;
  localparam logic [1:0] HIBA     = 2'd2;

  // Symbol codes: 0..9 are decimal digits, the rest are text glyphs
  localparam logic [3:0] SYM_DASH  = 4'd10;
  localparam logic [3:0] SYM_BLANK = 4'd11;
  localparam logic [3:0] SYM_E     = 4'd12;
  localparam logic [3:0] SYM_R     = 4'd13;

  logic          ready_q;
  logic [1:0]    allapot, allapot_n;
  logic [3:0]    q_r, q_n, m_r, m_n;
  logic [CW-1:0] oszto_cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic          cap, tc;
  logic          q_tens, m_tens;
  logic [3:0]    q_units, m_units;
  logic [3:0]    sym;

  // Active-low segment pattern g..a for a symbol code
  function automatic logic [6:0] glyph(input logic [3:0] s);
    case (s)
      4'd0:      glyph = 7'b1000000;
      4'd1:      glyph = 7'b1111001;
      4'd2:      glyph = 7'b0100100;
      4'd3:      glyph = 7'b0110000;
      4'd4:      glyph = 7'b0011001;
      4'd5:      glyph = 7'b0010010;
      4'd6:      glyph = 7'b0000010;
      4'd7:      glyph = 7'b1111000;
      4'd8:      glyph = 7'b0000000;
      4'd9:      glyph = 7'b0010000;
      SYM_DASH:  glyph = 7'b0111111;
      SYM_E:     glyph = 7'b0000110;
      SYM_R:     glyph = 7'b0101111;
      default:   glyph = 7'b1111111;
    endcase
  endfunction

  assign cap = ready & ~ready_q;
  assign tc  = (oszto_cnt == TC);

  // Next-state values; outputs are derived from these so new data and a new digit land together
  always_comb begin
    allapot_n = allapot;
    q_n       = q_r;
    m_n       = m_r;
    if (cap) begin
      if (hiba) begin
        allapot_n = HIBA;
      end else begin
        allapot_n = EREDMENY;
        q_n       = hanyados;
        m_n       = maradek;
      end
    end
    cnt_n = tc ? '0 : oszto_cnt + 1'b1;
    idx_n = tc ? idx + 2'd1 : idx;
  end

  // Decimal split of the 0..15 values and symbol selection for the digit being enabled next
  always_comb begin
    q_tens  = (q_n >= 4'd10);
    m_tens  = (m_n >= 4'd10);
    q_units = q_tens ? q_n - 4'd10 : q_n;
    m_units = m_tens ? m_n - 4'd10 : m_n;
    sym     = SYM_DASH;
    case (allapot_n)
      EREDMENY: begin
        case (idx_n)
          2'd3:    sym = q_tens ? 4'd1 : SYM_BLANK;
          2'd2:    sym = q_units;
          2'd1:    sym = m_tens ? 4'd1 : SYM_BLANK;
          default: sym = m_units;
        endcase
      end
      HIBA: begin
        case (idx_n)
          2'd3:    sym = SYM_E;
          2'd2:    sym = SYM_R;
          2'd1:    sym = SYM_R;
          default: sym = SYM_BLANK;
        endcase
      end
      default: sym = SYM_DASH;
    endcase
  end

  // State, capture registers, scan counters and registered display outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q   <= 1'b0;
      allapot   <= URES;
      q_r       <= 4'd0;
      m_r       <= 4'd0;
      oszto_cnt <= '0;
      idx       <= 2'd0;
      seg       <= 8'b10111111;
      an        <= 4'b1110;
    end else begin
      ready_q   <= ready;
      allapot   <= allapot_n;
      q_r       <= q_n;
      m_r       <= m_n;
      oszto_cnt <= cnt_n;
      idx       <= idx_n;
      seg       <= {1'b1, glyph(sym)};
      an        <= ~(4'b0001 << idx_n);
    end
  end

endmodule

// File: tb/tb_kijelzo_vezerlo.sv
// tb/tb_kijelzo_vezerlo.sv - self-checking bench for kijelzo_vezerlo
module tb_kijelzo_vezerlo;

  localparam int SD = 4;

  localparam logic [7:0] S0 = 8'b11000000;
  localparam logic [7:0] S1 = 8'b11111001;
  localparam logic [7:0] S2 = 8'b10100100;
  localparam logic [7:0] S3 = 8'b10110000;
  localparam logic [7:0] S4 = 8'b10011001;
  localparam logic [7:0] S5 = 8'b10010010;
  localparam logic [7:0] S6 = 8'b10000010;
  localparam logic [7:0] S7 = 8'b11111000;
  localparam logic [7:0] S8 = 8'b10000000;
  localparam logic [7:0] S9 = 8'b10010000;
  localparam logic [7:0] DA = 8'b10111111;
  localparam logic [7:0] BL = 8'b11111111;
  localparam logic [7:0] SE = 8'b10000110;
  localparam logic [7:0] SR = 8'b10101111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b0;
  logic       hiba = 1'b0;
  logic [3:0] hanyados = 4'd0;
  logic [3:0] maradek = 4'd0;
  logic [7:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;
  int m_cnt = 0;
  int m_idx = 0;
  logic [31:0] disp;
  logic [31:0] sb[$];

  typedef struct {
    logic        hiba;
    logic [3:0]  q;
    logic [3:0]  m;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  kijelzo_vezerlo #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .ready(ready), .hiba(hiba),
    .hanyados(hanyados), .maradek(maradek), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Reference scan position: slot of SD cycles, four slots per frame
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= 0;
      m_idx <= 0;
    end else if (m_cnt == SD - 1) begin
      m_cnt <= 0;
      m_idx <= (m_idx + 1) % 4;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Exactly one digit enabled on every cycle of the run
  always @(negedge clk) begin
    checks++;
    if ($countones(~an) != 1) begin
      errors++;
      $display("FAIL one_digit: an=%b has %0d enabled digits, required 1", an, $countones(~an));
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_now();
    logic [3:0] ea;
    ea = 4'b1111;
    ea[m_idx] = 1'b0;
    chk("an", {4'b0, an}, {4'b0, ea});
    chk("seg", seg, disp[m_idx*8 +: 8]);
  endtask

  task automatic check_cycles(input int n);
    repeat (n) begin
      check_now();
      @(negedge clk);
    end
  endtask

  task automatic take_result();
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty, required 1 entry");
    end else begin
      disp = sb.pop_front();
    end
  endtask

  task automatic pulse(input logic h, input logic [3:0] q, input logic [3:0] m, input logic [31:0] exp);
    hiba = h;
    hanyados = q;
    maradek = m;
    ready = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    ready = 1'b0;
    take_result();
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'd2,  4'd2,  {BL, S2, BL, S2}};
    vecs[1] = '{1'b0, 4'd15, 4'd0,  {S1, S5, BL, S0}};
    vecs[2] = '{1'b1, 4'd9,  4'd9,  {SE, SR, SR, BL}};
    vecs[3] = '{1'b0, 4'd4,  4'd1,  {BL, S4, BL, S1}};
    vecs[4] = '{1'b0, 4'd10, 4'd13, {S1, S0, S1, S3}};
    vecs[5] = '{1'b0, 4'd9,  4'd11, {BL, S9, S1, S1}};
    vecs[6] = '{1'b0, 4'd0,  4'd15, {BL, S0, S1, S5}};
    vecs[7] = '{1'b0, 4'd6,  4'd8,  {BL, S6, BL, S8}};
    vecs[8] = '{1'b0, 4'd14, 4'd12, {S1, S4, S1, S2}};
    vecs[9] = '{1'b0, 4'd8,  4'd10, {BL, S8, S1, S0}};
    disp = {DA, DA, DA, DA};

    // Reset state, then two frames of dashes
    #1 rst = 1'b0;
    #1;
    chk("reset_an", {4'b0, an}, 8'h0E);
    chk("reset_seg", seg, DA);
    repeat (3) @(negedge clk);
    check_now();
    rst = 1'b1;
    check_cycles(8 * SD);

    // Table of single-pulse results
    for (int i = 0; i < 10; i++) begin
      pulse(vecs[i].hiba, vecs[i].q, vecs[i].m, vecs[i].exp);
      check_cycles(4 * SD);
    end

    // Held ready captures once; input change while held is ignored
    hiba = 1'b0;
    hanyados = 4'd15;
    maradek = 4'd0;
    ready = 1'b1;
    sb.push_back({S1, S5, BL, S0});
    @(negedge clk);
    take_result();
    check_cycles(3);
    hanyados = 4'd3;
    check_cycles(7);
    ready = 1'b0;
    check_cycles(4);
    pulse(1'b0, 4'd3, 4'd0, {BL, S3, BL, S0});
    check_cycles(4 * SD);

    // Capture on the same edge as a prescaler terminal count
    for (int k = 0; k < 64 && m_cnt != SD - 1; k++) @(negedge clk);
    chk("tc_align", 8'(m_cnt), 8'(SD - 1));
    pulse(1'b0, 4'd11, 4'd5, {S1, S1, BL, S5});
    check_cycles(4 * SD);

    // Back-to-back pulses two cycles apart; last wins
    pulse(1'b0, 4'd7, 4'd3, {BL, S7, BL, S3});
    check_now();
    @(negedge clk);
    check_now();
    pulse(1'b0, 4'd12, 4'd9, {S1, S2, BL, S9});
    check_cycles(4 * SD);

    // Asynchronous reset mid-slot, ready already high at release
    #2 rst = 1'b0;
    #1;
    chk("async_an", {4'b0, an}, 8'h0E);
    chk("async_seg", seg, DA);
    disp = {DA, DA, DA, DA};
    hiba = 1'b0;
    hanyados = 4'd5;
    maradek = 4'd7;
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_now();
    rst = 1'b1;
    sb.push_back({BL, S5, BL, S7});
    @(negedge clk);
    ready = 1'b0;
    take_result();
    check_cycles(4 * SD);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
